// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring, bounded hold time
// per owner and a single dead (GAP) cycle between successive ownerships.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] owner,
  output logic [N-1:0]     ring,
  output logic             timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state, state_nx;
  logic [HOLD_W-1:0] hold, hold_nx;
  logic [N-1:0]      grant_nx, ring_nx;
  logic [IDX_W-1:0]  owner_nx;
  logic              timeout_nx;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [N-1:0]      win_onehot, win_rot;
  logic              owner_req;
  int                start;

  // Two-pass scan: first from the ring position upward, then wrap to bit 0.
  always_comb begin
    start      = 0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_rot    = '0;
    for (int i = 0; i < N; i++)
      if (ring[i]) start = i;
    for (int j = 0; j < N; j++)
      if (!win_found && j >= start && req[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    for (int j = 0; j < N; j++)
      if (!win_found && j < start && req[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    for (int j = 0; j < N; j++) begin
      win_onehot[j]         = win_found && (win_idx == IDX_W'(j));
      win_rot[(j + 1) % N]  = win_found && (win_idx == IDX_W'(j));
    end
  end

  // grant is one-hot on the owner, so this is req[owner] without a variable index
  assign owner_req = |(req & grant);

  always_comb begin
    state_nx   = state;
    hold_nx    = hold;
    grant_nx   = grant;
    owner_nx   = owner;
    ring_nx    = ring;
    timeout_nx = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (win_found) begin
          state_nx = GRANT;
          grant_nx = win_onehot;
          owner_nx = win_idx;
          ring_nx  = win_rot;
          hold_nx  = HOLD_W'(1);
        end else begin
          state_nx = IDLE;
          grant_nx = '0;
          owner_nx = '0;
          hold_nx  = '0;
        end
      end
      GRANT: begin
        if (done || !owner_req || hold == HOLD_W'(MAX_HOLD)) begin
          state_nx   = GAP;
          grant_nx   = '0;
          owner_nx   = '0;
          hold_nx    = '0;
          timeout_nx = !done && owner_req;
        end else begin
          hold_nx = hold + HOLD_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        owner_nx = '0;
        hold_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold        <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      owner       <= '0;
      ring        <= N'(1);
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      hold        <= hold_nx;
      grant       <= grant_nx;
      grant_valid <= |grant_nx;
      owner       <= owner_nx;
      ring        <= ring_nx;
      timeout     <= timeout_nx;
    end
  end

endmodule

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares one resource among N requesters using a one-hot ring pointer, the same rotating one-hot structure as the team's 4-bit ring counter. It sits in front of a shared datapath resource. Each cycle it holds at most one one-hot grant. It enforces a bounded hold time per owner and inserts one dead cycle between owners. Rotating priority after every grant guarantees starvation-free service.

## Interface
Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership (1..255).
- IDX_W, 2, width of owner index; must equal ceil(log2(N)).

Ports:
- clk  input  1  rising-edge clock; only clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  input  N  request per requester, level-sensitive.
- done  input  1  current owner finished; sampled only in GRANT.
- grant  output  N  one-hot grant, registered; all-zero when no owner.
- grant_valid  output  1  OR of grant, registered.
- owner  output  IDX_W  index of granted requester; 0 when grant_valid=0.
- ring  output  N  one-hot priority pointer, registered.
- timeout  output  1  one-cycle pulse: previous ownership ended by MAX_HOLD.

## Operation
- State machine: IDLE, GRANT, GAP. Reset state IDLE.
- Reset values: grant=0, grant_valid=0, owner=0, ring=1 (bit 0 set), timeout=0, hold counter=0.
- Arbitration (IDLE and GAP): scan req starting at the bit set in ring, ascending, wrapping at N-1→0. The first set bit wins.
- IDLE: if req≠0, then on the next edge go to GRANT. At that edge grant=winner one-hot, owner=winner index, and hold=1. ring becomes winner rotated left by one, so bit N-1 wraps to bit 0. If req=0, stay in IDLE.
- GRANT: release condition, checked in priority order:
  - done=1 → normal release, timeout stays 0.
  - req[owner]=0 → normal release.
  - hold==MAX_HOLD → forced release, timeout=1 on the next cycle.
  - Otherwise hold increments and the grant is held.
- On release the next edge enters GAP with grant=0, grant_valid=0, owner=0. ring is unchanged.
- GAP: lasts exactly one cycle.
  - Arbitrates like IDLE, so the next edge goes to GRANT if req≠0, else to IDLE.
  - timeout is 1 only during a GAP entered by a forced release.
- done or req changes outside GRANT have no effect other than the req vector seen by arbitration.
- done and hold==MAX_HOLD in the same cycle: normal release, no timeout.
- A timed-out requester still requesting competes normally. The ring has already advanced past it, so it wins again only if no other requester is active.
- Reset asserted mid-GRANT: all outputs clear immediately, without waiting for clk. The first edge after reset release evaluates from IDLE with ring=1.
- hold counter width is ceil(log2(MAX_HOLD+1)). It never wraps, because it is cleared on every new grant.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. req is sampled at edge k and grant is high after edge k.
- Release-to-next-grant: exactly 1 dead cycle (GAP) between two owners, including back-to-back grants to the same requester.
- Maximum ownership: MAX_HOLD cycles. Worst-case wait for a continuously requesting input is (N-1)·(MAX_HOLD+1) cycles.
- All outputs are registered. There are no combinational paths from req or done to outputs.

## Test plan
- Reset check: hold reset=0 with random req. Required: grant=0000, grant_valid=0, owner=0, ring=0001, timeout=0. Release reset with req=0 → stays in IDLE.
- Single requester: req=0100 at edge 1, done=1 during the 3rd grant cycle. Required: grant=0100 and owner=2 after edge 1, for 3 cycles, then one GAP cycle with grant=0000. ring=1000 from the first grant onward.
- Full contention: req=1111 constant, done=1 whenever grant_valid=1. Required grant sequence: 0001,0000,0010,0000,0100,0000,1000,0000,0001. ring follows 0010,0100,1000,0001,….
- Timeout: req=0010 constant, done=0, MAX_HOLD=8. Required: grant=0010 for exactly 8 cycles, then a GAP with timeout=1 for that cycle only, then grant=0010 again.
- Simultaneous events: in the 8th grant cycle assert done=1 with req[owner]=1. Required: normal release, timeout stays 0. Separately, drop req[owner] in grant cycle 2. Required: GAP on the next edge.
- Reset mid-operation: assert reset=0 between clock edges during GRANT with owner=3. Required: grant, owner and grant_valid go to 0 before the next edge, and ring=0001. After release with req=1010 → grant=0010 (owner 1) one edge later.
